// File: rtl/generic_down_counter_if.sv
// generic_down_counter_if: control, data and status bundle of the loadable down-counter.
interface generic_down_counter_if #(parameter int WIDTH = 5);
  logic             load;
  logic             enable;
  logic             reload_en;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             running;
  logic             done;
  modport master(output load, enable, reload_en, cnt_in, input cnt_out, tc, running, done);
  modport slave(input load, enable, reload_en, cnt_in, output cnt_out, tc, running, done);
endinterface

// File: rtl/generic_down_counter.sv
// generic_down_counter: loadable down-counter/timer with one-shot or auto-reload expiry and a one-cycle tc pulse.
module generic_down_counter #(
  parameter int WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  generic_down_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, r_reload, w_cnt_nxt;
  logic             r_tc, w_tc_nxt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= bus.load ? bus.cnt_in : r_reload;
      r_tc     <= w_tc_nxt;
    end
  end
  // RUN always holds a nonzero count, so the decrement can never pass below zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tc_nxt    = 1'b0;
    if (bus.load) begin
      w_cnt_nxt   = bus.cnt_in;
      w_state_nxt = (bus.cnt_in != '0) ? RUN : IDLE;
    end else if (r_state == RUN && bus.enable) begin
      if (r_cnt == WIDTH'(1)) begin
        w_tc_nxt    = 1'b1;
        w_cnt_nxt   = bus.reload_en ? r_reload : '0;
        w_state_nxt = bus.reload_en ? RUN : EXPIRED;
      end else if (r_cnt > WIDTH'(1)) begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
      end
    end
  end
  always_comb begin
    bus.cnt_out = r_cnt;
    bus.tc      = r_tc;
    bus.running = (r_state == RUN);
    bus.done    = (r_state == EXPIRED);
  end
endmodule
